// File: rtl/axil_cfg_arbiter.sv
// Two-requester round-robin arbiter and single-outstanding AXI4-Lite master
// with a per-transaction watchdog. Ports:
//   axi_clk/axi_rst_n : clock, async active-low reset
//   req_* / resp_*    : packed per-requester command and completion paths
//   m_aw*/m_w*/m_b*   : AXI4-Lite write channels
//   m_ar*/m_r*        : AXI4-Lite read channels
module axil_cfg_arbiter #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        axi_clk,
   input  logic        axi_rst_n,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_wr,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic [1:0]  req_ready,
   output logic [1:0]  resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] m_awaddr,
   output logic [2:0]  m_awprot,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready,
   output logic [31:0] m_araddr,
   output logic [2:0]  m_arprot,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rvalid,
   output logic        m_rready
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      RESP,
      DONE
   } state_e;

   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

   state_e      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        last_q, last_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [15:0] wdog_q, wdog_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [1:0]  rdy_q, rdy_d;

   logic        pick;
   logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
   logic        wdog_exp;

   // Channel valids/readies follow the state directly so they are
   // high from the first ADDR/RESP cycle and never outside it.
   assign m_awvalid = (state_q == ADDR) && wr_q && !aw_done_q;
   assign m_wvalid  = (state_q == ADDR) && wr_q && !w_done_q;
   assign m_arvalid = (state_q == ADDR) && !wr_q;
   assign m_bready  = (state_q == RESP) && wr_q;
   assign m_rready  = (state_q == RESP) && !wr_q;

   assign m_awaddr  = m_awvalid ? addr_q : 32'h0;
   assign m_wdata   = m_wvalid ? wdata_q : 32'h0;
   assign m_araddr  = m_arvalid ? addr_q : 32'h0;
   assign m_awprot  = 3'b000;
   assign m_arprot  = 3'b000;
   assign m_wstrb   = 4'hF;

   assign aw_hs = m_awvalid && m_awready;
   assign w_hs  = m_wvalid && m_wready;
   assign ar_hs = m_arvalid && m_arready;
   assign b_hs  = m_bready && m_bvalid;
   assign r_hs  = m_rready && m_rvalid;

   assign wdog_exp = (wdog_q == WDOG_LAST);

   assign req_ready  = rdy_q;
   assign resp_valid = (state_q == DONE) ? {gnt_q, ~gnt_q} : 2'b00;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      wdog_d    = wdog_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      rdy_d     = 2'b00;
      pick      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|req_valid) begin
               // A tie goes to whoever was not served last.
               if (&req_valid) pick = ~last_q;
               else            pick = req_valid[1];
               gnt_d     = pick;
               wr_d      = req_wr[pick];
               addr_d    = pick ? req_addr[63:32] : req_addr[31:0];
               wdata_d   = pick ? req_wdata[63:32] : req_wdata[31:0];
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               wdog_d    = 16'd0;
               rdy_d     = pick ? 2'b10 : 2'b01;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            wdog_d = wdog_q + 16'd1;
            if (wdog_exp) begin
               err_d   = 1'b1;
               rdata_d = 32'h0;
               state_d = DONE;
            end else if (wr_q) begin
               aw_done_d = aw_done_q | aw_hs;
               w_done_d  = w_done_q | w_hs;
               if (aw_done_d && w_done_d) state_d = RESP;
            end else if (ar_hs) begin
               state_d = RESP;
            end
         end
         RESP: begin
            wdog_d = wdog_q + 16'd1;
            if (wdog_exp) begin
               err_d   = 1'b1;
               rdata_d = 32'h0;
               state_d = DONE;
            end else if (wr_q && b_hs) begin
               err_d   = (m_bresp != 2'b00);
               rdata_d = 32'h0;
               state_d = DONE;
            end else if (!wr_q && r_hs) begin
               err_d   = (m_rresp != 2'b00);
               rdata_d = m_rdata;
               state_d = DONE;
            end
         end
         DONE: begin
            last_d  = gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk or negedge axi_rst_n) begin
      if (!axi_rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         wr_q      <= 1'b0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         wdog_q    <= 16'd0;
         rdata_q   <= 32'h0;
         err_q     <= 1'b0;
         rdy_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         wdog_q    <= wdog_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         rdy_q     <= rdy_d;
      end
   end

endmodule

// File: tb/tb_axil_cfg_arbiter.sv
// Bench for axil_cfg_arbiter: random requesters, AXI-Lite slave model,
// scoreboard of per-requester expected responses and bus payloads.
module tb_axil_cfg_arbiter;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   logic        clk, rst_n;
   logic [1:0]  req_ready, resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [2:0]  m_awprot, m_arprot;
   logic [3:0]  m_wstrb;
   logic        m_awvalid, m_awready, m_wvalid, m_wready;
   logic        m_bvalid, m_bready, m_arvalid, m_arready;
   logic        m_rvalid, m_rready;
   logic [1:0]  m_bresp, m_rresp;

   logic        rv [2];
   logic        rw [2];
   logic [31:0] ra [2];
   logic [31:0] rd [2];

   int   vectors = 0;
   int   miscompares = 0;
   int   wait_mode = 0;
   logic stall [5];
   logic tmo_mode = 1'b0;
   logic chk_lat = 1'b0;
   logic chk_spacing = 1'b0;
   logic chk_tmo = 1'b0;
   logic last_m = 1'b1;
   int   rdy_cnt [2];
   logic have_last = 1'b0;

   cmd_t cmd_cur [2];
   exp_t exq0 [$];
   exp_t exq1 [$];
   cmd_t bus_q [$];

   axil_cfg_arbiter #(.TIMEOUT_CYC(16)) dut (
      .axi_clk(clk), .axi_rst_n(rst_n),
      .req_valid({rv[1], rv[0]}), .req_wr({rw[1], rw[0]}),
      .req_addr({ra[1], ra[0]}), .req_wdata({rd[1], rd[0]}),
      .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      if (a == 32'h20) return 32'h1234_5678;
      return {a[15:0] ^ 16'hBEEF, a[15:0]};
   endfunction

   function automatic logic err_of(input logic [31:0] a);
      return a[5:2] == 4'hF;
   endfunction

   function automatic logic [1:0] resp_of(input logic [31:0] a);
      if (!err_of(a)) return 2'b00;
      return a[6] ? 2'b11 : 2'b10;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_ctl"}, {54'h0, m_awvalid, m_wvalid, m_arvalid, m_bready,
          m_rready, req_ready, resp_valid, resp_err}, 64'h0);
      chk({nm, "_addr"}, {m_awaddr, m_araddr}, 64'h0);
      chk({nm, "_data"}, {m_wdata, resp_rdata}, 64'h0);
      chk({nm, "_prot_strb"}, {54'h0, m_awprot, m_arprot, m_wstrb},
          64'h00F);
   endtask

   // Slave: each channel becomes ready/valid after a per-beat wait.
   int          wt [5];
   logic        rdy [5];
   logic        vld [5];
   logic [31:0] sl_waddr, sl_raddr;
   initial begin
      for (int c = 0; c < 5; c++) begin
         wt[c] = -1;
         rdy[c] = 1'b0;
         stall[c] = 1'b0;
      end
      sl_waddr = 0; sl_raddr = 0;
      m_awready = 0; m_wready = 0; m_arready = 0;
      m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
      forever begin
         @(posedge clk); #1;
         vld[0] = m_awvalid; vld[1] = m_wvalid; vld[2] = m_arvalid;
         vld[3] = m_bready;  vld[4] = m_rready;
         if (m_awvalid) sl_waddr = m_awaddr;
         if (m_arvalid) sl_raddr = m_araddr;
         for (int c = 0; c < 5; c++) begin
            if (!vld[c] || stall[c]) begin
               rdy[c] = 1'b0;
               wt[c] = -1;
            end else begin
               if (wt[c] < 0)
                  wt[c] = (wait_mode == 0) ? 0 :
                          (wait_mode == 1) ? int'($urandom_range(0, 3)) : 3;
               if (wt[c] == 0) rdy[c] = 1'b1;
               else begin
                  rdy[c] = 1'b0;
                  wt[c]--;
               end
            end
         end
         m_awready = rdy[0]; m_wready = rdy[1]; m_arready = rdy[2];
         m_bvalid = rdy[3];  m_rvalid = rdy[4];
         m_bresp = resp_of(sl_waddr);
         m_rresp = resp_of(sl_raddr);
         m_rdata = rd_of(sl_raddr);
      end
   end

   // Monitor: arbitration model, bus payload checks, response scoreboard.
   initial begin
      int   cyc, rdy_cyc, last_rdy_cyc, aw_run, r;
      logic [1:0] pv, eoh;
      logic eg;
      cmd_t hd;
      exp_t e;
      cyc = 0; rdy_cyc = 0; last_rdy_cyc = 0; aw_run = 0; pv = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            pv = 2'b00;
            aw_run = 0;
            continue;
         end
         if (req_ready != 2'b00) begin
            eg = (pv == 2'b11) ? ~last_m : (pv == 2'b10);
            eoh = (pv == 2'b00) ? 2'b00 : (eg ? 2'b10 : 2'b01);
            chk("grant", {62'h0, req_ready}, {62'h0, eoh});
            if (pv != 2'b00) begin
               last_m = eg;
               bus_q.push_back(cmd_cur[eg]);
            end
            if (req_ready[0]) rdy_cnt[0]++;
            if (req_ready[1]) rdy_cnt[1]++;
            if (chk_spacing && have_last)
               chk("grant_spacing", 64'(cyc - last_rdy_cyc), 64'd4);
            have_last = 1'b1;
            last_rdy_cyc = cyc;
            rdy_cyc = cyc;
         end
         if ((m_awvalid && m_awready) || (m_wvalid && m_wready) ||
             (m_arvalid && m_arready)) begin
            if (bus_q.size() == 0) begin
               chk("bus_unexpected", 64'h1, 64'h0);
            end else begin
               hd = bus_q[0];
               if (m_awvalid && m_awready)
                  chk("aw", {28'h0, hd.wr ^ 1'b1, m_awprot, m_awaddr},
                      {32'h0, hd.addr});
               if (m_wvalid && m_wready)
                  chk("w", {28'h0, m_wstrb, m_wdata},
                      {28'h0, 4'hF, hd.wdata});
               if (m_arvalid && m_arready)
                  chk("ar", {28'h0, hd.wr, m_arprot, m_araddr},
                      {32'h0, hd.addr});
            end
         end
         if (resp_valid != 2'b00) begin
            r = resp_valid[1] ? 1 : 0;
            chk("resp_onehot", {62'h0, resp_valid},
                r ? 64'h2 : 64'h1);
            if ((r == 0 && exq0.size() == 0) ||
                (r == 1 && exq1.size() == 0)) begin
               chk("resp_unexpected", {62'h0, resp_valid}, 64'h0);
            end else begin
               e = (r == 0) ? exq0.pop_front() : exq1.pop_front();
               chk(r ? "resp1" : "resp0",
                   {31'h0, resp_err, resp_rdata}, {31'h0, e.err, e.rdata});
               if (bus_q.size() != 0) void'(bus_q.pop_front());
               if (chk_lat)
                  chk("resp_latency", 64'(cyc - rdy_cyc), 64'd2);
            end
         end
         if (m_awvalid) aw_run++;
         else begin
            if (aw_run > 0 && chk_tmo)
               chk("tmo_aw_len", 64'(aw_run), 64'd16);
            aw_run = 0;
         end
         pv = {rv[1], rv[0]};
      end
   end

   task automatic issue(input int r, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd);
      exp_t e;
      int   k;
      @(posedge clk); #1;
      cmd_cur[r] = '{wr: wr, addr: a, wdata: wd};
      if (tmo_mode) begin
         e.rdata = 32'h0;
         e.err = 1'b1;
      end else begin
         e.rdata = wr ? 32'h0 : rd_of(a);
         e.err = err_of(a);
      end
      if (r == 0) exq0.push_back(e);
      else        exq1.push_back(e);
      rw[r] = wr; ra[r] = a; rd[r] = wd; rv[r] = 1'b1;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (req_ready[r]) break;
      end
      if (k == 300) chk("req_ready_timeout", 64'(r), 64'hFF);
      @(posedge clk); #1;
      rv[r] = 1'b0;
      ra[r] = $urandom();
      rd[r] = $urandom();
      rw[r] = 1'($urandom());
   endtask

   task automatic drive_req(input int r, input int n, input int maxgap);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(posedge clk);
         a = {$urandom_range(0, 65535), 16'h0} |
             {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              2'b00};
         issue(r, 1'($urandom()), a, $urandom());
      end
   endtask

   task automatic wait_idle(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (exq0.size() == 0 && exq1.size() == 0) break;
      end
      if (k == budget) chk("drain_timeout", 64'(exq0.size() + exq1.size()),
                           64'h0);
      @(negedge clk);
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rv[i] = 0; rw[i] = 0; ra[i] = 0; rd[i] = 0; rdy_cnt[i] = 0;
      end
      #3;
      chk_reset_outs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Zero-wait write from requester 0
      wait_mode = 0;
      chk_lat = 1'b1;
      issue(0, 1'b1, 32'h0000_0004, 32'hA5A5_0001);
      wait_idle(50);

      // Read from requester 1 with three wait cycles per beat
      wait_mode = 2;
      chk_lat = 1'b0;
      issue(1, 1'b0, 32'h0000_0020, 32'h0);
      wait_idle(50);

      // Continuous contention: strict alternation, 4-cycle spacing
      wait_mode = 0;
      chk_lat = 1'b1;
      chk_spacing = 1'b1;
      have_last = 1'b0;
      rdy_cnt[0] = 0; rdy_cnt[1] = 0;
      fork
         drive_req(0, 3, 0);
         drive_req(1, 3, 0);
      join
      wait_idle(50);
      chk("ready_cnt0", 64'(rdy_cnt[0]), 64'd3);
      chk("ready_cnt1", 64'(rdy_cnt[1]), 64'd3);
      chk_spacing = 1'b0;

      // SLVERR write, then a normal read
      issue(0, 1'b1, 32'h0000_003C, 32'hDEAD_0003);
      wait_idle(50);
      issue(1, 1'b0, 32'h0000_0008, 32'h0);
      wait_idle(50);
      chk_lat = 1'b0;

      // Random traffic with random wait states
      wait_mode = 1;
      fork
         drive_req(0, 12, 3);
         drive_req(1, 12, 3);
      join
      wait_idle(200);

      // Watchdog: AW never accepted
      wait_mode = 0;
      stall[0] = 1'b1;
      tmo_mode = 1'b1;
      chk_tmo = 1'b1;
      issue(0, 1'b1, 32'h0000_0010, 32'h0BAD_F00D);
      wait_idle(100);
      stall[0] = 1'b0;
      tmo_mode = 1'b0;
      chk_tmo = 1'b0;
      issue(1, 1'b0, 32'h0000_0014, 32'h0);
      wait_idle(50);

      // Asynchronous reset while waiting in RESP
      stall[4] = 1'b1;
      issue(1, 1'b0, 32'h0000_0024, 32'h0);
      for (k = 0; k < 50; k++) begin
         if (m_rready) break;
         @(negedge clk);
      end
      if (k == 50) chk("rready_timeout", 64'h0, 64'h1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outs("async_reset");
      exq0.delete();
      exq1.delete();
      bus_q.delete();
      last_m = 1'b1;
      stall[4] = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      fork
         issue(0, 1'b1, 32'h0000_0030, 32'h5555_AAAA);
         issue(1, 1'b0, 32'h0000_0034, 32'h0);
      join
      wait_idle(50);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
